// File: rtl/wb_scoreboard.sv
// Writeback-stream checker: compares each retiring rd!=0 write, in order, against an expected-result FIFO.
// Counters and flags update one cycle after the retire; exp_ready drops only while the FIFO is full.

module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_dat,
  output logic                   push_rdy,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Occupancy never exceeds DEPTH, so its top bit alone means full.
  assign push_rdy = ~count[AW];
  assign do_push  = push_vld & push_rdy;
  assign do_pop   = pop & (count != '0);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module wb_scoreboard #(
  parameter int DEPTH        = 32,
  parameter int CNT_W        = 16,
  parameter bit STOP_ON_FAIL = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   exp_valid,
  input  logic [4:0]             exp_rd,
  input  logic [31:0]            exp_data,
  output logic                   exp_ready,
  input  logic [4:0]             rsw_scoreboard,
  input  logic [31:0]            Write_scoreboard,
  output logic [CNT_W-1:0]       pass_count,
  output logic [CNT_W-1:0]       fail_count,
  output logic [CNT_W-1:0]       bubble_count,
  output logic                   mismatch,
  output logic                   unexpected,
  output logic [4:0]             first_fail_rd,
  output logic [31:0]            first_fail_data,
  output logic [36:0]            first_fail_exp,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   halted
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]  state;
  logic [36:0] head;
  logic        active;
  logic        fifo_empty;
  logic        retire;
  logic        is_pass;
  logic        is_mis;
  logic        is_unx;
  logic        is_fail;
  logic        is_bubble;

  // A same-cycle push into an empty FIFO is invisible here because emptiness comes from registered occupancy.
  assign fifo_empty = (pending == '0);
  assign active     = (state == RUN) && en;
  assign retire     = active && (rsw_scoreboard != 5'd0);
  assign is_bubble  = active && (rsw_scoreboard == 5'd0);
  assign is_pass    = retire && !fifo_empty && (head == {rsw_scoreboard, Write_scoreboard});
  assign is_mis     = retire && !fifo_empty && (head != {rsw_scoreboard, Write_scoreboard});
  assign is_unx     = retire && fifo_empty;
  assign is_fail    = is_mis || is_unx;
  assign halted     = (state == HALT);

  wb_fifo #(
    .W     (37),
    .DEPTH (DEPTH)
  ) u_exp_fifo (
    .clk      (clk),
    .reset    (reset),
    .push_vld (exp_valid),
    .push_dat ({exp_rd, exp_data}),
    .push_rdy (exp_ready),
    .pop      (retire && !fifo_empty),
    .head_dat (head),
    .count    (pending)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      pass_count      <= '0;
      fail_count      <= '0;
      bubble_count    <= '0;
      mismatch        <= 1'b0;
      unexpected      <= 1'b0;
      first_fail_rd   <= '0;
      first_fail_data <= '0;
      first_fail_exp  <= '0;
    end else begin
      if (is_pass && (pass_count != '1))     pass_count   <= pass_count + CNT_ONE;
      if (is_fail && (fail_count != '1))     fail_count   <= fail_count + CNT_ONE;
      if (is_bubble && (bubble_count != '1)) bubble_count <= bubble_count + CNT_ONE;
      if (is_mis) mismatch   <= 1'b1;
      if (is_unx) unexpected <= 1'b1;

      if (is_fail && !mismatch && !unexpected) begin
        first_fail_rd   <= rsw_scoreboard;
        first_fail_data <= Write_scoreboard;
        first_fail_exp  <= is_mis ? head : 37'd0;
      end

      case (state)
        IDLE:    if (en) state <= RUN;
        RUN: begin
          if (is_fail && STOP_ON_FAIL) state <= HALT;
          else if (!en)                state <= IDLE;
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: two instances (free-running and stop-on-fail) against a queue-based reference model.
module tb_wb_scoreboard;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int PW    = 3;
  localparam int CMAX  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, exp_valid;
  logic [4:0]  exp_rd, rsw;
  logic [31:0] exp_data, wdat;

  logic          rdy0, rdy1, mm0, mm1, ux0, ux1, hl0, hl1;
  logic [CW-1:0] pc0, pc1, fc0, fc1, bc0, bc1;
  logic [4:0]    frd0, frd1;
  logic [31:0]   fd0, fd1;
  logic [36:0]   fe0, fe1;
  logic [PW-1:0] pend0, pend1;

  wb_scoreboard #(.DEPTH(DEPTH), .CNT_W(CW), .STOP_ON_FAIL(1'b0)) dut0 (
    .clk(clk), .reset(rst_n), .en(en), .exp_valid(exp_valid), .exp_rd(exp_rd),
    .exp_data(exp_data), .exp_ready(rdy0), .rsw_scoreboard(rsw), .Write_scoreboard(wdat),
    .pass_count(pc0), .fail_count(fc0), .bubble_count(bc0), .mismatch(mm0),
    .unexpected(ux0), .first_fail_rd(frd0), .first_fail_data(fd0), .first_fail_exp(fe0),
    .pending(pend0), .halted(hl0));

  wb_scoreboard #(.DEPTH(DEPTH), .CNT_W(CW), .STOP_ON_FAIL(1'b1)) dut1 (
    .clk(clk), .reset(rst_n), .en(en), .exp_valid(exp_valid), .exp_rd(exp_rd),
    .exp_data(exp_data), .exp_ready(rdy1), .rsw_scoreboard(rsw), .Write_scoreboard(wdat),
    .pass_count(pc1), .fail_count(fc1), .bubble_count(bc1), .mismatch(mm1),
    .unexpected(ux1), .first_fail_rd(frd1), .first_fail_data(fd1), .first_fail_exp(fe1),
    .pending(pend1), .halted(hl1));

  int n_chk = 0;
  int n_err = 0;

  // Reference model: one queue per instance, unbounded integer counts clipped on compare.
  logic [36:0] mq0[$];
  logic [36:0] mq1[$];
  int          m_pass[2], m_fail[2], m_bub[2];
  logic        m_mm[2], m_ux[2], m_halt[2], m_run[2];
  logic [4:0]  m_frd[2];
  logic [31:0] m_fd[2];
  logic [36:0] m_fe[2];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int          sz;
      logic [36:0] hd;
      logic        act, mis, ux, pu, po, fl;
      sz = (k == 0) ? mq0.size() : mq1.size();
      hd = '0;
      if (sz > 0) hd = (k == 0) ? mq0[0] : mq1[0];
      if (!rst_n) begin
        m_pass[k] = 0; m_fail[k] = 0; m_bub[k] = 0;
        m_mm[k] = 0; m_ux[k] = 0; m_halt[k] = 0; m_run[k] = 0;
        m_frd[k] = '0; m_fd[k] = '0; m_fe[k] = '0;
        if (k == 0) mq0.delete(); else mq1.delete();
      end else begin
        pu  = exp_valid && (sz < DEPTH);
        act = m_run[k] && en;
        mis = 0; ux = 0; po = 0;
        if (act && rsw == 5'd0) m_bub[k]++;
        if (act && rsw != 5'd0) begin
          if (sz == 0) ux = 1;
          else begin
            po = 1;
            if (hd == {rsw, wdat}) m_pass[k]++;
            else mis = 1;
          end
        end
        fl = mis || ux;
        if (fl) m_fail[k]++;
        if (fl && !m_mm[k] && !m_ux[k]) begin
          m_frd[k] = rsw; m_fd[k] = wdat; m_fe[k] = mis ? hd : 37'd0;
        end
        if (mis) m_mm[k] = 1;
        if (ux)  m_ux[k] = 1;
        if (po) begin
          if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
        end
        if (pu) begin
          if (k == 0) mq0.push_back({exp_rd, exp_data}); else mq1.push_back({exp_rd, exp_data});
        end
        if (!m_halt[k]) begin
          if (fl && k == 1) begin m_halt[k] = 1; m_run[k] = 0; end
          else m_run[k] = en;
        end
      end
    end
  endtask

  task automatic check_dut(input int k, input logic rdy, input logic [CW-1:0] pc, fc, bc,
                           input logic mm, ux, input logic [4:0] frd, input logic [31:0] fd,
                           input logic [36:0] fe, input logic [PW-1:0] pend, input logic hl);
    int sz;
    sz = (k == 0) ? mq0.size() : mq1.size();
    chk($sformatf("d%0d_pass", k), pc, sat(m_pass[k]));
    chk($sformatf("d%0d_fail", k), fc, sat(m_fail[k]));
    chk($sformatf("d%0d_bubble", k), bc, sat(m_bub[k]));
    chk($sformatf("d%0d_mismatch", k), mm, m_mm[k]);
    chk($sformatf("d%0d_unexpected", k), ux, m_ux[k]);
    chk($sformatf("d%0d_ff_rd", k), frd, m_frd[k]);
    chk($sformatf("d%0d_ff_data", k), fd, m_fd[k]);
    chk($sformatf("d%0d_ff_exp", k), fe, m_fe[k]);
    chk($sformatf("d%0d_pending", k), pend, sz);
    chk($sformatf("d%0d_exp_ready", k), rdy, sz < DEPTH);
    chk($sformatf("d%0d_halted", k), hl, m_halt[k]);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_dut(0, rdy0, pc0, fc0, bc0, mm0, ux0, frd0, fd0, fe0, pend0, hl0);
    check_dut(1, rdy1, pc1, fc1, bc1, mm1, ux1, frd1, fd1, fe1, pend1, hl1);
  endtask

  task automatic set_push(input logic v, input logic [4:0] rd, input logic [31:0] d);
    exp_valid = v; exp_rd = rd; exp_data = d;
  endtask

  task automatic set_ret(input logic [4:0] rd, input logic [31:0] d);
    rsw = rd; wdat = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; set_push(0, 0, 0); set_ret(0, 0); en = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0;
    set_push(0, 0, 0); set_ret(0, 0);
    tick(); tick();
    chk("rst_exp_ready", rdy0, 1);
    chk("rst_pending", pend0, 0);
    rst_n = 1'b1;

    // In-order matching retires
    set_push(1, 5'd1, 32'h12345000); tick();
    set_push(1, 5'd2, 32'd3);        tick();
    set_push(1, 5'd3, 32'd5);        tick();
    set_push(0, 0, 0); en = 1'b1;    tick();
    set_ret(5'd1, 32'h12345000);     tick();
    set_ret(5'd2, 32'd3);            tick();
    set_ret(5'd3, 32'd5);            tick();
    set_ret(0, 0); en = 1'b0;        tick();
    chk("tp1_pass", pc0, 3);
    chk("tp1_fail", fc0, 0);
    chk("tp1_pending", pend0, 0);
    chk("tp1_mismatch", mm0, 0);

    // Data mismatch, stop-on-fail freezes dut1
    do_reset();
    set_push(1, 5'd2, 32'd3); tick();
    set_push(0, 0, 0); en = 1'b1; tick();
    set_ret(5'd2, 32'd4); tick();
    chk("tp2_fail", fc1, 1);
    chk("tp2_mismatch", mm1, 1);
    chk("tp2_ff_rd", frd1, 2);
    chk("tp2_ff_data", fd1, 4);
    chk("tp2_ff_exp", fe1, {5'd2, 32'd3});
    chk("tp2_halted", hl1, 1);
    set_ret(0, 0); set_push(1, 5'd2, 32'd3); tick();
    set_push(0, 0, 0); set_ret(5'd2, 32'd3); tick();
    set_ret(0, 0); en = 1'b0; tick();
    chk("tp2_pass_halted", pc1, 0);
    chk("tp2_pass_running", pc0, 1);

    // Load-use bubbles between two entries
    do_reset();
    set_push(1, 5'd21, 32'h57ff); tick();
    set_push(1, 5'd2, 32'h5800);  tick();
    set_push(0, 0, 0); en = 1'b1; tick();
    set_ret(5'd21, 32'h57ff); tick();
    set_ret(0, 0); tick(); tick();
    set_ret(5'd2, 32'h5800); tick();
    set_ret(0, 0); en = 1'b0; tick();
    chk("tp3_pass", pc0, 2);
    chk("tp3_bubble", bc0, 2);

    // Retire into empty FIFO while pushing the same entry
    do_reset();
    en = 1'b1; tick();
    set_push(1, 5'd5, 32'd2); set_ret(5'd5, 32'd2); tick();
    chk("tp4_unexpected", ux0, 1);
    chk("tp4_fail", fc0, 1);
    chk("tp4_pending", pend0, 1);
    chk("tp4_ff_exp", fe0, 0);
    set_push(0, 0, 0); set_ret(0, 0); en = 1'b0; tick();

    // Fill, dropped push, then pointer wrap with concurrent push/pop
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_push(1, 5'($urandom_range(1, 31)), $urandom); tick();
    end
    set_push(1, 5'd9, 32'hdead); tick();
    chk("tp5_full_ready", rdy0, 0);
    chk("tp5_full_pending", pend0, 4);
    set_push(0, 0, 0); en = 1'b1; tick();
    set_ret(mq0[0][36:32], mq0[0][31:0]); tick();
    for (int i = 0; i < 6; i++) begin
      set_push(1, 5'($urandom_range(1, 31)), $urandom);
      set_ret(mq0[0][36:32], mq0[0][31:0]);
      tick();
    end
    chk("tp5_wrap_pass", pc0, 7);
    chk("tp5_wrap_pending", pend0, 3);

    // Reset mid-stream beats a simultaneous push and retire
    set_push(1, 5'd4, 32'd4); set_ret(mq0[0][36:32], mq0[0][31:0]);
    rst_n = 1'b0; tick();
    chk("tp6_pass", pc0, 0);
    chk("tp6_pending", pend0, 0);
    chk("tp6_exp_ready", rdy0, 1);
    chk("tp6_halted", hl1, 0);
    rst_n = 1'b1; set_push(0, 0, 0); set_ret(0, 0); en = 1'b0;

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      int r;
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 9) != 0);
      set_push($urandom_range(0, 2) != 0, 5'($urandom_range(1, 31)), $urandom);
      r = $urandom_range(0, 9);
      if (r < 3) set_ret(0, 0);
      else if (r < 8 && mq0.size() > 0) set_ret(mq0[0][36:32], mq0[0][31:0]);
      else if (r == 8 && mq0.size() > 0) set_ret(mq0[0][36:32], mq0[0][31:0] ^ 32'h1);
      else set_ret(5'($urandom_range(0, 31)), $urandom);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
